// File: rtl/zynet_axi_lite_regs.sv
// AXI4-Lite slave register file for zyNet: weight/bias load strobes, layer and
// neuron select, soft reset, and result/status readback with a level interrupt.
module zynet_axi_lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int dataWidth          = 16
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic                            weight_valid,
    output logic [dataWidth-1:0]            weight_value,
    output logic                            bias_valid,
    output logic [dataWidth-1:0]            bias_value,
    output logic [31:0]                     layer_num,
    output logic [31:0]                     neuron_num,
    output logic                            soft_reset,
    input  logic                            net_out_valid,
    input  logic [31:0]                     net_out_class,
    input  logic [dataWidth-1:0]            neuron_out_data,
    output logic                            neuron_out_pop,
    output logic                            intr
);

    localparam logic [2:0] REG_WEIGHT = 3'd0;
    localparam logic [2:0] REG_BIAS   = 3'd1;
    localparam logic [2:0] REG_CLASS  = 3'd2;
    localparam logic [2:0] REG_LAYER  = 3'd3;
    localparam logic [2:0] REG_NEURON = 3'd4;
    localparam logic [2:0] REG_NOUT   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam logic [2:0] REG_SOFT   = 3'd7;

    logic [2:0]                    wr_idx;
    logic [2:0]                    rd_idx;
    logic                          wr_accept;
    logic                          rd_accept;
    logic [31:0]                   class_reg;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                          unused_inputs;

    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                             s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign wr_idx = s_axi_awaddr[4:2];
    assign rd_idx = s_axi_araddr[4:2];

    // Address and data are only taken together, so no partial write state is held.
    assign wr_accept     = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
    assign s_axi_awready = wr_accept;
    assign s_axi_wready  = wr_accept;
    assign rd_accept     = s_axi_arvalid && !s_axi_rvalid;
    assign s_axi_arready = rd_accept;

    assign s_axi_bresp    = 2'b00;
    assign s_axi_rresp    = 2'b00;
    assign neuron_out_pop = rd_accept && (rd_idx == REG_NOUT);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_bvalid <= 1'b0;
            weight_valid <= 1'b0;
            weight_value <= '0;
            bias_valid   <= 1'b0;
            bias_value   <= '0;
            layer_num    <= '0;
            neuron_num   <= '0;
            soft_reset   <= 1'b1;
        end else begin
            weight_valid <= 1'b0;
            bias_valid   <= 1'b0;
            if (wr_accept) begin
                s_axi_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
            if (wr_accept) begin
                case (wr_idx)
                    REG_WEIGHT: begin
                        weight_value <= s_axi_wdata[dataWidth-1:0];
                        weight_valid <= 1'b1;
                    end
                    REG_BIAS: begin
                        bias_value <= s_axi_wdata[dataWidth-1:0];
                        bias_valid <= 1'b1;
                    end
                    REG_LAYER:  layer_num  <= s_axi_wdata[31:0];
                    REG_NEURON: neuron_num <= s_axi_wdata[31:0];
                    REG_SOFT:   soft_reset <= s_axi_wdata[0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            REG_CLASS:  rd_mux = class_reg;
            REG_LAYER:  rd_mux = layer_num;
            REG_NEURON: rd_mux = neuron_num;
            REG_NOUT:   rd_mux = {{(C_S_AXI_DATA_WIDTH-dataWidth){1'b0}}, neuron_out_data};
            REG_STATUS: rd_mux = {{(C_S_AXI_DATA_WIDTH-2){1'b0}}, soft_reset, intr};
            REG_SOFT:   rd_mux = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, soft_reset};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
        end else begin
            if (rd_accept) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_mux;
            end else if (s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // A new result outranks a concurrent class read, so the interrupt is never lost.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            class_reg <= '0;
            intr      <= 1'b0;
        end else begin
            if (!soft_reset && net_out_valid) begin
                class_reg <= net_out_class;
            end
            if (soft_reset) begin
                intr <= 1'b0;
            end else if (net_out_valid) begin
                intr <= 1'b1;
            end else if (rd_accept && (rd_idx == REG_CLASS)) begin
                intr <= 1'b0;
            end
        end
    end

endmodule

// File: doc/zynet_axi_lite_regs.md
Name: zynet_axi_lite_regs

Overview:
AXI4-Lite slave register file for zyNet configuration and result readback. It sits between the PS/bench AXI master and the network core. It decodes register writes into weight and bias load strobes, layer/neuron select and soft reset. It returns the detected class, per-neuron outputs and status, and raises intr when a result is ready.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, AXI byte-address width; word index = addr[4:2]
dataWidth, 16, width of weight/bias/neuron-output values

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  5  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid/s_axi_awready  in/out  1  write address handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  ignored (full-word writes only)
s_axi_wvalid/s_axi_wready  in/out  1  write data handshake
s_axi_bresp  out  2  always 2'b00
s_axi_bvalid/s_axi_bready  out/in  1  write response handshake
s_axi_araddr  in  5  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid/s_axi_arready  in/out  1  read address handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00
s_axi_rvalid/s_axi_rready  out/in  1  read data handshake
weight_valid  out  1  one-cycle pulse, weight_value valid
weight_value  out  dataWidth  wdata[dataWidth-1:0] of last 0x00 write
bias_valid  out  1  one-cycle pulse, bias_value valid
bias_value  out  dataWidth  wdata[dataWidth-1:0] of last 0x04 write
layer_num  out  32  layer select register
neuron_num  out  32  neuron select register
soft_reset  out  1  active-high core reset
net_out_valid  in  1  one-cycle pulse from core: result ready
net_out_class  in  32  detected class, sampled on net_out_valid
neuron_out_data  in  dataWidth  head of core's neuron-output FIFO
neuron_out_pop  out  1  one-cycle pulse, head consumed
intr  out  1  level interrupt, result pending

Behaviour:
- Reset (async, aresetn=0): all ready/valid outputs 0, rdata 0, weight/bias strobes and values 0, layer_num 0, neuron_num 0, soft_reset 1, intr 0, class register 0.
- Write: awready and wready asserted together for exactly one cycle when awvalid & wvalid & !bvalid. A lone awvalid or lone wvalid is not accepted. The write takes effect in that accept cycle. bvalid rises next cycle and is held until bready. No new write is accepted while bvalid=1.
- Read: arready asserted one cycle when arvalid & !rvalid. rdata is registered and rvalid rises next cycle, held stable until rready.
- Register map (word offset):
  - 0x00 W: weight_value <= wdata, weight_valid pulses the cycle after accept.
  - 0x04 W: same for bias.
  - 0x08 R: class register. Reading clears intr.
  - 0x0C RW: layer_num.
  - 0x10 RW: neuron_num.
  - 0x14 R: rdata = zero-extended neuron_out_data. neuron_out_pop pulses one cycle at read accept.
  - 0x18 R: status; bit0 = intr, bit1 = soft_reset, others 0.
  - 0x1C RW: soft_reset = wdata[0].
  - Unmapped offsets: writes dropped, reads return 0. bresp/rresp remain OKAY.
  - Writes to read-only offsets are ignored. Reads of 0x00/0x04 return 0.
- Result capture: on net_out_valid, class register <= net_out_class and intr <= 1.
- Same-cycle net_out_valid and a 0x08 read accept: rdata returns the old class, intr stays 1 (set wins).
- soft_reset=1 forces intr to 0 and ignores net_out_valid.
- Back-to-back: sustained throughput is one write per 2 cycles when bready is tied high; reads likewise.
- Write and read channels are independent. Simultaneous write and read accepts in one cycle are legal. A read of a RW register in the same cycle it is written returns the old value.

Test Plan:
- Reset then read 0x1C, 0x18, 0x0C -> 0x1, 0x2, 0x0. Write 0x1C=0 then read 0x18 -> 0x0.
- Write 0x0C=3, 0x10=29, read both -> 3 and 29; layer_num/neuron_num ports show 3/29 the cycle after accept.
- Write 0x00=0x0000ABCD 784 times, bready always 1 -> 784 weight_valid pulses, each with value 0xABCD. awready/wready never asserted while bvalid=1.
- With soft_reset=0, pulse net_out_valid with class 7 -> intr=1, 0x18 bit0=1. Read 0x08 -> 7, intr=0 after read. Repeat with a simultaneous pulse and read -> intr stays 1.
- Hold rready low 10 cycles during a 0x14 read -> rvalid/rdata stable throughout, exactly one neuron_out_pop.
- Present awvalid 5 cycles before wvalid -> no accept until both are high. Assert aresetn low mid-transaction -> bvalid=0 and soft_reset=1 immediately.
